fetch_line_responder: RTL and testbench
=======================================

Name: fetch_line_responder

Overview:
- Responder side of the fetch PC handshake. Accepts instruction-fetch requests (PC) from fetch and returns the 32-bit instruction word.
- Its `fetch_resp_valid` is the `sig_recvd` that advances the fetch PC.
- Holds one 64-byte line buffer. Hits return in one cycle; misses run an 8-beat read burst on the system bus.
- Sits between fetch and the memory bus arbiter.

Parameters:
- ADDR_W, 64, fetch/bus address width
- BUS_W, 64, bus data beat width
- LINE_BEATS, 8, beats per line (line = LINE_BEATS*BUS_W/8 = 64 bytes)
- TAG_W, 13, bus request tag width

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- fetch_req_valid  in  1  request pending; fetch holds it and fetch_req_addr stable until fetch_resp_valid or fetch_flush
- fetch_req_addr  in  ADDR_W  byte PC; bits [1:0] ignored (treated as aligned down)
- fetch_flush  in  1  jump redirect; cancels any outstanding request
- fetch_resp_valid  out  1  one-cycle pulse, instruction delivered (drives sig_recvd)
- fetch_resp_instr  out  32  instruction word
- fetch_resp_addr  out  ADDR_W  PC the instruction belongs to
- fetch_busy  out  1  state != IDLE
- bus_reqcyc  out  1  bus read request valid
- bus_req  out  ADDR_W  line-aligned address (low 6 bits zero)
- bus_reqtag  out  TAG_W  constant REQTAG_READ_MEM
- bus_reqack  in  1  request accepted
- bus_respcyc  in  1  response beat valid
- bus_resp  in  BUS_W  response beat data
- bus_respack  out  1  beat consumed

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; line_valid=0; beat_cnt=0; drop=0.
  - All outputs 0: fetch_resp_valid, bus_reqcyc, bus_respack, fetch_busy, fetch_resp_instr, fetch_resp_addr, bus_req, bus_reqtag.
- States: IDLE, REQ, FILL, RESP.
- IDLE:
  - req_valid & !flush & line_valid & addr[ADDR_W-1:6]==line_tag: go RESP. Latch the instruction and address. Hit latency is 1 cycle.
  - req_valid & !flush & miss: latch addr into req_addr, go REQ.
- REQ:
  - bus_reqcyc=1 and bus_req={req_addr[ADDR_W-1:6],6'b0} held stable until bus_reqack.
  - On ack: beat_cnt=0, go FILL.
  - Request cannot be withdrawn once raised.
- FILL:
  - Each cycle with bus_respcyc: bus_respack=1 combinationally; line[beat_cnt]=bus_resp; beat_cnt++.
  - On the beat with beat_cnt==LINE_BEATS-1: line_valid=1, line_tag=req_addr[ADDR_W-1:6].
  - Then go RESP if !drop, else go IDLE and clear drop.
  - Gaps between beats are allowed.
- RESP:
  - fetch_resp_valid=1 for exactly one cycle, then IDLE.
  - Next request is accepted the following cycle.
- Instruction select: beat = addr[5:3]; addr[2]=0 selects bits [31:0], addr[2]=1 selects [63:32] (little-endian).
- Miss latency: last beat in cycle L gives fetch_resp_valid in L+1.
- fetch_flush:
  - In IDLE: no request is captured that cycle. The redirected request is sampled the next cycle.
  - In RESP: fetch_resp_valid is forced 0 (gated combinationally), state goes to IDLE.
  - In REQ/FILL: set drop. The bus transaction completes normally and the line is still installed, but no response is issued.
  - Flush in the same cycle as the last beat behaves as drop.
- Flush in REQ/FILL also latches the pending redirect as follows:
  - If fetch_req_valid is high on return to IDLE, that request is served normally.
  - A redirect target inside the just-filled line becomes a hit.
- bus_respcyc while IDLE/REQ/RESP: stray beat. Ack it (bus_respack=1) and discard so the bus never hangs. This covers beats in flight across a reset.
- beat_cnt width: clog2(LINE_BEATS). It wraps to 0 after the last beat.
- fetch_busy=1 in REQ, FILL, RESP.

Decomposition:
- Package fetch_pkg holds:
  - enum fetch_resp_state_t {IDLE, REQ, FILL, RESP}
  - LINE_BYTES=64, LINE_OFF_W=6
  - REQTAG_READ_MEM (TAG_W-bit read/memory tag)
  - function instr_sel(line, addr) returning the 32-bit word
- One sub-module, fetch_line_buf:
  - LINE_BEATS x BUS_W register array with beat write port.
  - Holds tag/valid.
  - Combinational 32-bit read mux.
- The FSM stays in the top.

Test Plan:
- Cold miss: reset, req addr 0x1000; bus acks 2 cycles later and returns beats 0..7 = {0x11111111_00000013, ...}. Then bus_req=0x1000 and resp_instr=0x00000013 exactly 1 cycle after beat 7, single pulse.
- Hit: after the fill above, req 0x100C gives resp_valid the next cycle, instr = beat1[63:32]. No bus_reqcyc.
- Line crossing: req 0x1040 after the 0x1000 line is resident is a miss, bus_req=0x1040. Then 0x1000 misses again (single line).
- Flush mid-fill: miss 0x2000, flush at beat 3, redirect req 0x2010. All 8 beats are still acked, no response for 0x2000. Then 0x2010 hits and returns 1 cycle after entering IDLE.
- Flush in RESP cycle: resp_valid stays 0 that cycle, state returns IDLE. Stray bus_respcyc in IDLE gets respack=1 and no state change.
- Async reset mid-FILL at beat 5: outputs 0 immediately, line_valid=0. Remaining beats are acked and discarded, and the next req 0x2000 re-misses.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types, geometry constants and the word-select helper for the fetch line responder.
package fetch_pkg;

    // Default geometry; the top exposes these as parameters.
    localparam int ADDR_W_DEF     = 64;
    localparam int BUS_W_DEF      = 64;
    localparam int LINE_BEATS_DEF = 8;
    localparam int TAG_W_DEF      = 13;

    localparam int LINE_BYTES = 64;
    localparam int LINE_OFF_W = 6;
    localparam int LINE_BITS  = LINE_BYTES * 8;

    // Bus tag marking a read of main memory.
    localparam logic [TAG_W_DEF-1:0] REQTAG_READ_MEM = 13'h0002;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } fetch_resp_state_t;

    // Pick the 32-bit instruction out of a little-endian line.
    // addr[5:3] selects the beat, addr[2] the half; addr[1:0] are ignored.
    function automatic logic [31:0] instr_sel(input logic [LINE_BITS-1:0]  line,
                                              input logic [LINE_OFF_W-1:0] addr);
        return line[{addr[LINE_OFF_W-1:2], 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/fetch_line_buf.sv
// Single-line instruction buffer: beat-wide write port, tag/valid, and a
// combinational 32-bit read mux with hit detection.
module fetch_line_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int BUS_W      = BUS_W_DEF,
    parameter int LINE_BEATS = LINE_BEATS_DEF,
    localparam int BEAT_W    = $clog2(LINE_BEATS),
    localparam int LTAG_W    = ADDR_W - LINE_OFF_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [BEAT_W-1:0] wr_beat,
    input  logic [BUS_W-1:0]  wr_data,
    input  logic              install,
    input  logic [LTAG_W-1:0] install_tag,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_hit,
    output logic [31:0]       rd_instr
);

    logic [BUS_W-1:0]     line_q [LINE_BEATS];
    logic                 line_valid_q;
    logic [LTAG_W-1:0]    line_tag_q;
    logic [LINE_BITS-1:0] line_flat;

    // Beat write port for the line data.
    // NOTE: the data array has no reset; line_valid_q alone says whether its contents mean anything.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            // NOTE: non-blocking so every register updates from pre-edge values, independent of statement order.
            line_q[wr_beat] <= wr_data;
        end
    end

    // Tag and valid are installed together when the last beat lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_valid_q <= 1'b0;
            line_tag_q   <= '0;
        end else if (install) begin
            line_valid_q <= 1'b1;
            line_tag_q   <= install_tag;
        end
    end

    // Flatten the beat array into one little-endian line vector.
    always_comb begin
        line_flat = '0;
        for (int i = 0; i < LINE_BEATS; i++) begin
            line_flat[i*BUS_W +: BUS_W] = line_q[i];
        end
    end

    assign rd_hit   = line_valid_q && (line_tag_q == rd_addr[ADDR_W-1:LINE_OFF_W]);
    assign rd_instr = instr_sel(line_flat, rd_addr[LINE_OFF_W-1:0]);

endmodule

// File: rtl/fetch_line_responder.sv
// Fetch-side responder: serves PC requests from a one-line buffer, refilling
// it with an 8-beat bus burst on a miss. fetch_resp_valid advances the PC.
module fetch_line_responder
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int BUS_W      = BUS_W_DEF,
    parameter int LINE_BEATS = LINE_BEATS_DEF,
    parameter int TAG_W      = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_req_valid,
    input  logic [ADDR_W-1:0] fetch_req_addr,
    input  logic              fetch_flush,
    output logic              fetch_resp_valid,
    output logic [31:0]       fetch_resp_instr,
    output logic [ADDR_W-1:0] fetch_resp_addr,
    output logic              fetch_busy,
    output logic              bus_reqcyc,
    output logic [ADDR_W-1:0] bus_req,
    output logic [TAG_W-1:0]  bus_reqtag,
    input  logic              bus_reqack,
    input  logic              bus_respcyc,
    input  logic [BUS_W-1:0]  bus_resp,
    output logic              bus_respack
);

    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    fetch_resp_state_t state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              drop_q, drop_d;
    logic [31:0]       resp_instr_q, resp_instr_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;

    logic              buf_wr_en;
    logic              buf_install;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic              buf_hit;
    logic [31:0]       buf_instr;
    logic [31:0]       fill_instr;

    // In IDLE look up the incoming PC; otherwise look up the PC being filled.
    assign buf_rd_addr = (state_q == IDLE) ? fetch_req_addr : req_addr_q;

    fetch_line_buf #(
        .ADDR_W    (ADDR_W),
        .BUS_W     (BUS_W),
        .LINE_BEATS(LINE_BEATS)
    ) u_line_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (buf_wr_en),
        .wr_beat    (beat_cnt_q),
        .wr_data    (bus_resp),
        .install    (buf_install),
        .install_tag(req_addr_q[ADDR_W-1:LINE_OFF_W]),
        .rd_addr    (buf_rd_addr),
        .rd_hit     (buf_hit),
        .rd_instr   (buf_instr)
    );

    // The requested word may sit in the beat arriving this cycle, which is not yet in the buffer.
    assign fill_instr = (req_addr_q[LINE_OFF_W-1:3] == beat_cnt_q)
                      ? (req_addr_q[2] ? bus_resp[32 +: 32] : bus_resp[31:0])
                      : buf_instr;

    // State register and response/request latches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            beat_cnt_q   <= '0;
            drop_q       <= 1'b0;
            resp_instr_q <= '0;
            resp_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            beat_cnt_q   <= beat_cnt_d;
            drop_q       <= drop_d;
            resp_instr_q <= resp_instr_d;
            resp_addr_q  <= resp_addr_d;
        end
    end

    // Next-state logic, buffer write control and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d          = state_q;
        req_addr_d       = req_addr_q;
        beat_cnt_d       = beat_cnt_q;
        drop_d           = drop_q;
        resp_instr_d     = resp_instr_q;
        resp_addr_d      = resp_addr_q;
        buf_wr_en        = 1'b0;
        buf_install      = 1'b0;
        bus_reqcyc       = 1'b0;
        fetch_resp_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fetch_req_valid && !fetch_flush) begin
                    if (buf_hit) begin
                        resp_instr_d = buf_instr;
                        resp_addr_d  = {fetch_req_addr[ADDR_W-1:2], 2'b00};
                        state_d      = RESP;
                    end else begin
                        req_addr_d = fetch_req_addr;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                bus_reqcyc = 1'b1;
                if (fetch_flush) drop_d = 1'b1;
                if (bus_reqack) begin
                    beat_cnt_d = '0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (fetch_flush) drop_d = 1'b1;
                if (bus_respcyc) begin
                    buf_wr_en  = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        // The line is installed even if the requester went away.
                        buf_install = 1'b1;
                        if (drop_q || fetch_flush) begin
                            drop_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            resp_instr_d = fill_instr;
                            resp_addr_d  = {req_addr_q[ADDR_W-1:2], 2'b00};
                            state_d      = RESP;
                        end
                    end
                end
            end
            RESP: begin
                fetch_resp_valid = !fetch_flush;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Beats are always consumed so the bus never stalls; outside FILL they are simply discarded.
    assign bus_respack      = bus_respcyc & reset_n;
    assign bus_req          = bus_reqcyc ? {req_addr_q[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}} : '0;
    assign bus_reqtag       = bus_reqcyc ? TAG_W'(REQTAG_READ_MEM) : '0;
    assign fetch_busy       = (state_q != IDLE);
    assign fetch_resp_instr = resp_instr_q;
    assign fetch_resp_addr  = resp_addr_q;

endmodule

// File: tb/tb_fetch_line_responder.sv
// Directed bench for fetch_line_responder: table of fetch transactions plus
// hand-written flush and reset sequences. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_fetch_line_responder;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_req_valid = 1'b0;
    logic [63:0] fetch_req_addr = '0;
    logic        fetch_flush = 1'b0;
    logic        fetch_resp_valid;
    logic [31:0] fetch_resp_instr;
    logic [63:0] fetch_resp_addr;
    logic        fetch_busy;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack = 1'b0;
    logic        bus_respcyc = 1'b0;
    logic [63:0] bus_resp = '0;
    logic        bus_respack;

    int checks = 0;
    int failures = 0;

    fetch_line_responder dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .fetch_req_valid (fetch_req_valid),
        .fetch_req_addr  (fetch_req_addr),
        .fetch_flush     (fetch_flush),
        .fetch_resp_valid(fetch_resp_valid),
        .fetch_resp_instr(fetch_resp_instr),
        .fetch_resp_addr (fetch_resp_addr),
        .fetch_busy      (fetch_busy),
        .bus_reqcyc      (bus_reqcyc),
        .bus_req         (bus_req),
        .bus_reqtag      (bus_reqtag),
        .bus_reqack      (bus_reqack),
        .bus_respcyc     (bus_respcyc),
        .bus_resp        (bus_resp),
        .bus_respack     (bus_respack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        bit          exp_miss;
        logic [31:0] exp_instr;
        logic [63:0] exp_addr;
    } vec_t;

    vec_t vecs [7];

    // Memory image: line 0x1000 beat i = {0x11111111*(i+1), 0x13 + i*0x100}; other lines are XOR-tweaked.
    function automatic logic [63:0] mem_beat(input logic [63:0] la, input int i);
        logic [31:0] hi;
        logic [31:0] lo;
        hi = (32'h1111_1111 * 32'(i + 1)) ^ (la[31:0] - 32'h1000);
        lo = la[31:0] ^ 32'h1000 ^ (32'h13 + 32'(i << 8));
        return {hi, lo};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Presents one beat for a cycle; respack must follow respcyc combinationally.
    task automatic send_beat(input logic [63:0] la, input int i);
        bus_resp    = mem_beat(la, i);
        bus_respcyc = 1'b1;
        #1 check("respack_on_beat", bus_respack, 1);
        step();
        bus_respcyc = 1'b0;
        bus_resp    = '0;
    endtask

    // Called with bus_reqcyc already observed; acks two cycles later and ends in FILL.
    task automatic grant_req(input logic [63:0] exp_req);
        step();
        check("req_held_cyc", bus_reqcyc, 1);
        check("req_held_addr", bus_req, exp_req);
        step();
        check("req_held_cyc2", bus_reqcyc, 1);
        bus_reqack = 1'b1;
        step();
        bus_reqack = 1'b0;
        check("fill_busy", fetch_busy, 1);
        check("fill_no_reqcyc", bus_reqcyc, 0);
    endtask

    // One full fetch transaction, miss path with a one-cycle gap before beat 3.
    task automatic run_vec(input vec_t v, input string tag);
        logic [63:0] la;
        la = {v.addr[63:6], 6'b0};
        fetch_req_addr  = v.addr;
        fetch_req_valid = 1'b1;
        step();
        if (v.exp_miss) begin
            check({tag, "_reqcyc"}, bus_reqcyc, 1);
            check({tag, "_bus_req"}, bus_req, la);
            check({tag, "_reqtag"}, bus_reqtag, 64'(REQTAG_READ_MEM));
            check({tag, "_no_resp_req"}, fetch_resp_valid, 0);
            grant_req(la);
            for (int i = 0; i < 8; i++) begin
                if (i == 3) begin
                    #1 check({tag, "_gap_no_ack"}, bus_respack, 0);
                    step();
                end
                send_beat(la, i);
                if (i < 7) check({tag, "_no_resp_fill"}, fetch_resp_valid, 0);
            end
        end else begin
            check({tag, "_hit_no_bus"}, bus_reqcyc, 0);
        end
        check({tag, "_resp_valid"}, fetch_resp_valid, 1);
        check({tag, "_resp_instr"}, fetch_resp_instr, v.exp_instr);
        check({tag, "_resp_addr"}, fetch_resp_addr, v.exp_addr);
        fetch_req_valid = 1'b0;
        step();
        check({tag, "_single_pulse"}, fetch_resp_valid, 0);
        check({tag, "_idle"}, fetch_busy, 0);
    endtask

    initial begin
        vecs[0] = '{64'h1000, 1'b1, 32'h0000_0013, 64'h1000}; // cold miss
        vecs[1] = '{64'h100C, 1'b0, 32'h2222_2222, 64'h100C}; // hit, beat1 upper
        vecs[2] = '{64'h103B, 1'b0, 32'h0000_0713, 64'h1038}; // hit, last beat lower, [1:0] ignored
        vecs[3] = '{64'h1040, 1'b1, 32'h0000_0053, 64'h1040}; // next line misses
        vecs[4] = '{64'h1074, 1'b0, 32'h7777_7737, 64'h1074}; // hit in new line
        vecs[5] = '{64'h1000, 1'b1, 32'h0000_0013, 64'h1000}; // old line evicted
        vecs[6] = '{64'h1018, 1'b0, 32'h0000_0313, 64'h1018}; // hit, beat3 lower

        // Reset state
        step();
        step();
        check("rst_resp_valid", fetch_resp_valid, 0);
        check("rst_busy", fetch_busy, 0);
        check("rst_reqcyc", bus_reqcyc, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_reqtag", bus_reqtag, 0);
        check("rst_instr", fetch_resp_instr, 0);
        check("rst_addr", fetch_resp_addr, 0);
        check("rst_respack", bus_respack, 0);
        reset_n = 1'b1;
        step();

        foreach (vecs[k]) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Flush mid-fill: miss 0x2000, flush + redirect to 0x2010 on beat 3.
        fetch_req_addr  = 64'h2000;
        fetch_req_valid = 1'b1;
        step();
        check("fl_reqcyc", bus_reqcyc, 1);
        check("fl_bus_req", bus_req, 64'h2000);
        grant_req(64'h2000);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                fetch_flush    = 1'b1;
                fetch_req_addr = 64'h2010;
            end
            send_beat(64'h2000, i);
            fetch_flush = 1'b0;
            check("fl_no_resp", fetch_resp_valid, 0);
        end
        check("fl_back_idle", fetch_busy, 0);
        step();
        check("fl_redirect_hit", fetch_resp_valid, 1);
        check("fl_redirect_instr", fetch_resp_instr, 32'h0000_3213);
        check("fl_redirect_addr", fetch_resp_addr, 64'h2010);
        check("fl_redirect_no_bus", bus_reqcyc, 0);
        fetch_req_valid = 1'b0;
        step();
        check("fl_pulse_end", fetch_resp_valid, 0);

        // Flush during RESP: pulse suppressed, back to IDLE.
        fetch_req_addr  = 64'h2008;
        fetch_req_valid = 1'b1;
        step();
        check("fr_in_resp", fetch_busy, 1);
        fetch_flush     = 1'b1;
        fetch_req_valid = 1'b0;
        #1 check("fr_valid_gated", fetch_resp_valid, 0);
        step();
        fetch_flush = 1'b0;
        check("fr_idle", fetch_busy, 0);
        check("fr_no_valid", fetch_resp_valid, 0);

        // Stray beat in IDLE is acked and ignored.
        bus_respcyc = 1'b1;
        bus_resp    = 64'hDEAD_BEEF_DEAD_BEEF;
        #1 check("stray_ack", bus_respack, 1);
        step();
        bus_respcyc = 1'b0;
        check("stray_idle", fetch_busy, 0);
        check("stray_no_req", bus_reqcyc, 0);
        check("stray_no_resp", fetch_resp_valid, 0);

        // Async reset in the middle of a fill at beat 5.
        fetch_req_addr  = 64'h3000;
        fetch_req_valid = 1'b1;
        step();
        check("ar_reqcyc", bus_reqcyc, 1);
        grant_req(64'h3000);
        for (int i = 0; i < 5; i++) send_beat(64'h3000, i);
        bus_resp    = mem_beat(64'h3000, 5);
        bus_respcyc = 1'b1;
        #2 reset_n  = 1'b0;
        fetch_req_valid = 1'b0;
        #1;
        check("ar_busy", fetch_busy, 0);
        check("ar_respack", bus_respack, 0);
        check("ar_reqcyc0", bus_reqcyc, 0);
        check("ar_instr", fetch_resp_instr, 0);
        check("ar_addr", fetch_resp_addr, 0);
        step();
        reset_n = 1'b1;
        #1 check("ar_stray5_ack", bus_respack, 1);
        step();
        bus_respcyc = 1'b0;
        check("ar_still_idle", fetch_busy, 0);
        send_beat(64'h3000, 6);
        send_beat(64'h3000, 7);
        check("ar_after_stray", fetch_busy, 0);
        check("ar_after_stray_resp", fetch_resp_valid, 0);
        run_vec('{64'h2000, 1'b1, 32'h0000_3013, 64'h2000}, "ar_remiss");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
